ppu_writer: RTL and testbench

Bus initiator that drives the PPU's table-write port (chipselect/write/address/writedata) from a queue of write commands. It sits between a command source (HPS bridge or on-chip game logic) and the PPU, and can hold a command back until the start of vertical blank so attribute, sprite and colour updates land between frames without tearing. It issues at most one PPU write per clock, drops commands aimed at the unmapped region, and reports queue occupancy and the drop count.

---
 rtl/ppu_writer.sv | 120 ++++++++++++
 tb/tb_ppu_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_writer.sv
// PPU table-write bus initiator: queues write commands and issues at most one
// PPU write per clock, holding barrier commands until the start of vertical blank.
module ppu_writer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned VACTIVE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_addr,
  input  logic [31:0]              cmd_data,
  input  logic                     cmd_barrier,
  input  logic [9:0]               vcount,
  output logic                     chipselect,
  output logic                     write,
  output logic [15:0]              address,
  output logic [31:0]              writedata,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_count,
  output logic                     vblank_start
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_VB} state_t;
  state_t state, state_next;

  logic [48:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic          head_barrier, head_unmapped;
  logic [15:0]   head_addr;
  logic [31:0]   head_data;
  logic          vb, vb_q, vb_rise, armed;

  assign cmd_ready     = (count != (AW+1)'(DEPTH));
  assign level         = count;
  assign push          = cmd_valid && cmd_ready;
  assign {head_barrier, head_addr, head_data} = mem[rd_ptr];
  assign head_unmapped = (head_addr[9:8] == 2'b11);
  assign vb            = (vcount >= 10'(VACTIVE));
  assign vb_rise       = vb && !vb_q;
  assign write         = chipselect;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_barrier, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // A vblank edge seen while already in WAIT_VB's entry cycle leaves armed set,
  // so WAIT_VB also releases on armed to avoid losing a whole frame.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:    if (count != '0) state_next = ISSUE;
      ISSUE: begin
        if (count == '0)                  state_next = IDLE;
        else if (!head_barrier || armed)  pop        = 1'b1;
        else                              state_next = WAIT_VB;
      end
      WAIT_VB: if (vb_rise || armed) state_next = ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new vblank edge re-arms even if it coincides with a barrier pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_q         <= 1'b0;
      vblank_start <= 1'b0;
      armed        <= 1'b0;
    end else begin
      vb_q         <= vb;
      vblank_start <= vb_rise;
      if (vb_rise)                   armed <= 1'b1;
      else if (pop && head_barrier)  armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chipselect <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      drop_count <= '0;
    end else begin
      chipselect <= pop && !head_unmapped;
      if (pop && !head_unmapped) begin
        address   <= head_addr;
        writedata <= head_data;
      end
      if (pop && head_unmapped && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ppu_writer.sv
// Directed and randomized checks of ppu_writer against an ordered write queue
// and a saturating drop counter.
module tb_ppu_writer;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready, cmd_barrier;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [9:0]  vcount;
  logic        chipselect, write, vblank_start;
  logic [15:0] address;
  logic [31:0] writedata;
  logic [4:0]  level;
  logic [7:0]  drop_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_drops = 0;
  logic [47:0] exp_q [$];

  ppu_writer #(.DEPTH(16), .VACTIVE(480)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_barrier(cmd_barrier),
    .vcount(vcount),
    .chipselect(chipselect), .write(write), .address(address), .writedata(writedata),
    .level(level), .drop_count(drop_count), .vblank_start(vblank_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [15:0] a, input logic [31:0] d);
    if (a[9:8] == 2'b11) exp_drops = (exp_drops >= 255) ? 255 : exp_drops + 1;
    else                 exp_q.push_back({a, d});
  endtask

  // One clock; afterwards every bus write is matched against the expected order.
  task automatic step();
    logic [47:0] e;
    @(posedge clk); #1;
    chk("write_eq_cs", 64'(write), 64'(chipselect));
    if (chipselect) begin
      if (exp_q.size() == 0) chk("spurious_write", 64'(chipselect), 64'h0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(address), 64'(e[47:32]));
        chk("wr_data", 64'(writedata), 64'(e[31:0]));
      end
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d, input logic b);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_barrier = b;
    if (cmd_ready) model_accept(a, d);
    step();
    cmd_valid = 1'b0; cmd_barrier = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < 500) begin step(); n++; end
    repeat (3) step();
    chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'h0);
    chk({tag, "_level"}, 64'(level), 64'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cs"}, 64'(chipselect), 64'h0);
    chk({tag, "_wr"}, 64'(write), 64'h0);
    chk({tag, "_addr"}, 64'(address), 64'h0);
    chk({tag, "_data"}, 64'(writedata), 64'h0);
    chk({tag, "_level"}, 64'(level), 64'h0);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'h1);
    chk({tag, "_drops"}, 64'(drop_count), 64'h0);
    chk({tag, "_vbs"}, 64'(vblank_start), 64'h0);
  endtask

  initial begin
    logic [15:0] a;
    int prev_v, pulses;
    logic exp_vbs;

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_barrier = 1'b0; vcount = 10'd0;
    #2;
    chk_reset_state("rst");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(); step();

    // Three back-to-back writes from empty: first on the bus two edges after acceptance
    push(16'h0000, 32'h11111111, 1'b0);
    chk("t2_cs_e1", 64'(chipselect), 64'h0);
    push(16'h0105, 32'h00000022, 1'b0);
    chk("t2_cs_e2", 64'(chipselect), 64'h0);
    push(16'h0203, 32'h00000033, 1'b0);
    chk("t2_cs_e3", 64'(chipselect), 64'h1);
    chk("t2_addr0", 64'(address), 64'h0000);
    step(); chk("t2_cs_e4", 64'(chipselect), 64'h1); chk("t2_addr1", 64'(address), 64'h0105);
    step(); chk("t2_cs_e5", 64'(chipselect), 64'h1); chk("t2_addr2", 64'(address), 64'h0203);
    step(); chk("t2_cs_e6", 64'(chipselect), 64'h0); chk("t2_level", 64'(level), 64'h0);

    // Barrier held until vblank rising edge
    vcount = 10'd100; step();
    push(16'h0001, 32'h0000ABCD, 1'b1);
    repeat (6) begin
      step();
      chk("t3_hold_cs", 64'(chipselect), 64'h0);
      chk("t3_hold_vbs", 64'(vblank_start), 64'h0);
    end
    chk("t3_level", 64'(level), 64'h1);
    vcount = 10'd480; step();
    chk("t3_vbs", 64'(vblank_start), 64'h1);
    chk("t3_cs_r", 64'(chipselect), 64'h0);
    step();
    chk("t3_cs_r1", 64'(chipselect), 64'h1);
    chk("t3_addr", 64'(address), 64'h0001);
    chk("t3_data", 64'(writedata), 64'h0000ABCD);
    chk("t3_vbs_once", 64'(vblank_start), 64'h0);
    step(); chk("t3_cs_r2", 64'(chipselect), 64'h0);
    repeat (3) begin step(); chk("t3_vbs_hold", 64'(vblank_start), 64'h0); end
    vcount = 10'd100; step(); chk("t3_vbs_fall", 64'(vblank_start), 64'h0);

    // One unmapped, one mapped
    push(16'h0300, 32'h5, 1'b0);
    push(16'h0001, 32'h6, 1'b0);
    drain("t4");
    chk("t4_drop1", 64'(drop_count), 64'h1);

    // Random mixed traffic with idle gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) push(16'($urandom), $urandom, 1'b0);
      else step();
    end
    drain("rnd");
    chk("rnd_drops", 64'(drop_count), 64'(exp_drops));

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      a[9:8] = 2'b11;
      push(a, $urandom, 1'b0);
    end
    drain("sat");
    chk("sat_model", 64'(drop_count), 64'(exp_drops));
    chk("sat_255", 64'(drop_count), 64'hFF);

    // Fill behind a waiting barrier; a 17th command is refused through the release pop
    push(16'h0210, $urandom, 1'b1);
    for (int i = 0; i < 15; i++) begin
      push(16'($urandom), $urandom, 1'b0);
      chk("t5_fill_cs", 64'(chipselect), 64'h0);
    end
    chk("t5_full_level", 64'(level), 64'h10);
    chk("t5_full_ready", 64'(cmd_ready), 64'h0);
    cmd_valid = 1'b1; cmd_addr = 16'h0111; cmd_data = 32'h17; cmd_barrier = 1'b0;
    vcount = 10'd480;
    step();
    chk("t5_r_level", 64'(level), 64'h10);
    chk("t5_r_ready", 64'(cmd_ready), 64'h0);
    chk("t5_r_vbs", 64'(vblank_start), 64'h1);
    step();
    chk("t5_pop_level", 64'(level), 64'hF);
    chk("t5_pop_cs", 64'(chipselect), 64'h1);
    cmd_valid = 1'b0;
    drain("t5");

    // Vblank while empty arms the next barrier; the one after waits again
    vcount = 10'd100; step(); step();
    vcount = 10'd480; step();
    chk("t6_vbs", 64'(vblank_start), 64'h1);
    vcount = 10'd100; step();
    push(16'h0042, 32'hCAFE0042, 1'b1);
    step(); chk("t6_b1_cs_n", 64'(chipselect), 64'h0);
    step(); chk("t6_b1_cs", 64'(chipselect), 64'h1); chk("t6_b1_addr", 64'(address), 64'h0042);
    step(); chk("t6_b1_cs_off", 64'(chipselect), 64'h0);
    push(16'h0043, 32'hCAFE0043, 1'b1);
    repeat (8) begin step(); chk("t6_b2_hold", 64'(chipselect), 64'h0); end
    vcount = 10'd480; step();
    chk("t6_b2_vbs", 64'(vblank_start), 64'h1);
    chk("t6_b2_cs_r", 64'(chipselect), 64'h0);
    step(); chk("t6_b2_cs", 64'(chipselect), 64'h1); chk("t6_b2_addr", 64'(address), 64'h0043);
    step(); chk("t6_b2_cs_off", 64'(chipselect), 64'h0);

    // Asynchronous reset with 5 queued and a write on the bus
    vcount = 10'd100; step();
    push(16'h0050, 32'h50, 1'b1);
    for (int i = 0; i < 6; i++) push(16'h0060 + 16'(i), 32'h60 + 32'(i), 1'b0);
    chk("t7_level7", 64'(level), 64'h7);
    vcount = 10'd480; step();
    step(); step();
    chk("t7_pre_cs", 64'(chipselect), 64'h1);
    chk("t7_pre_level", 64'(level), 64'h5);
    reset = 1'b1; #1;
    chk_reset_state("t7_rst");
    exp_q.delete();
    exp_drops = 0;
    vcount = 10'd100;
    repeat (2) @(posedge clk);
    #1 chk("t7_ready_in_rst", 64'(cmd_ready), 64'h1);
    reset = 1'b0;
    repeat (20) step();
    chk("t7_post_level", 64'(level), 64'h0);
    chk("t7_post_ready", 64'(cmd_ready), 64'h1);
    chk("t7_post_drops", 64'(drop_count), 64'h0);

    // Two full frames of vcount: one pulse per frame, none on the 524->0 wrap
    prev_v = 100; pulses = 0;
    for (int f = 0; f < 2; f++) begin
      for (int v = 0; v < 525; v++) begin
        vcount = 10'(v);
        step();
        exp_vbs = (v >= 480) && (prev_v < 480);
        chk("sweep_vbs", 64'(vblank_start), 64'(exp_vbs));
        if (vblank_start) pulses++;
        prev_v = v;
      end
    end
    chk("sweep_pulses", 64'(pulses), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
